// File: rtl/tlc_pkg.sv
// ---------------------------------------------------------------------------
// tlc_pkg
// Shared types and constants for the two-way traffic light controller.
//   tlc_state_e  : 3-bit controller state. FLASH has a reserved code even
//                  when the flashing feature is not built; in that build the
//                  code is treated as illegal.
//   lamp_t       : one direction's {red, yellow, green} lamp bundle.
//   lamp_bus_t   : both directions plus the pedestrian walk lamp.
//   DEF_*        : default parameter values for the top module.
//   decode_lamps : Moore lamp decode of a state.
// ---------------------------------------------------------------------------
package tlc_pkg;

  typedef enum logic [2:0] {
    ST_ARN   = 3'd0,  // all-red, north-south next
    ST_NSG   = 3'd1,
    ST_NSY   = 3'd2,
    ST_ARE   = 3'd3,  // all-red, east-west next
    ST_EWG   = 3'd4,
    ST_EWY   = 3'd5,
    ST_WALK  = 3'd6,
    ST_FLASH = 3'd7
  } tlc_state_e;

  typedef struct packed {
    logic red;
    logic yellow;
    logic green;
  } lamp_t;

  typedef struct packed {
    lamp_t ns;
    lamp_t ew;
    logic  walk;
  } lamp_bus_t;

  localparam int DEF_TICK_DIV   = 50_000_000;
  localparam int DEF_GREEN_S    = 20;
  localparam int DEF_YELLOW_S   = 3;
  localparam int DEF_RED_CLR_S  = 2;
  localparam int DEF_PED_WALK_S = 10;
  localparam int DEF_CNT_W      = 8;

  localparam lamp_t LAMP_RED    = 3'b100;
  localparam lamp_t LAMP_YELLOW = 3'b010;
  localparam lamp_t LAMP_GREEN  = 3'b001;

  // Every direction defaults to red, so any unlisted code is a safe all-red.
  function automatic lamp_bus_t decode_lamps(input tlc_state_e st, input logic flash_on);
    lamp_bus_t lamps;
    lamps.ns   = LAMP_RED;
    lamps.ew   = LAMP_RED;
    lamps.walk = 1'b0;
    case (st)
      ST_NSG:  lamps.ns = LAMP_GREEN;
      ST_NSY:  lamps.ns = LAMP_YELLOW;
      ST_EWG:  lamps.ew = LAMP_GREEN;
      ST_EWY:  lamps.ew = LAMP_YELLOW;
      ST_WALK: lamps.walk = 1'b1;
      ST_FLASH: begin
        lamps.ns = {1'b0, flash_on, 1'b0};
        lamps.ew = {1'b0, flash_on, 1'b0};
      end
      default: lamps.walk = 1'b0;
    endcase
    return lamps;
  endfunction

endpackage

// File: rtl/tlc_tick_gen.sv
// ---------------------------------------------------------------------------
// tlc_tick_gen
// Prescaler producing a one-cycle tick every TICK_DIV enabled clocks.
//   clk      : clock
//   reset    : asynchronous, active-high reset (counter to 0)
//   i_enable : 1 = count, 0 = hold counter and suppress tick
//   o_tick   : high for the single cycle in which the counter is TICK_DIV-1
// TICK_DIV must be at least 2.
// ---------------------------------------------------------------------------
module tlc_tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_enable,
  output logic o_tick
);

  localparam int                DIV_W   = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0]  DIV_MAX = DIV_W'(TICK_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_ONE = DIV_W'(32'd1);
  localparam logic [DIV_W-1:0]  DIV_ZERO = {DIV_W{1'b0}};

  logic [DIV_W-1:0] r_div;
  logic             w_at_max;

  assign w_at_max = (r_div == DIV_MAX);

  // Divider counter: wraps after TICK_DIV-1, frozen while disabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div <= DIV_ZERO;
    end else if (i_enable) begin
      r_div <= w_at_max ? DIV_ZERO : (r_div + DIV_ONE);
    end else begin
      r_div <= r_div;
    end
  end

  // Gated by enable so a freeze landing on the terminal count emits nothing.
  assign o_tick = w_at_max & i_enable;

endmodule

// File: rtl/traffic_light_ctrl_2way.sv
// ---------------------------------------------------------------------------
// traffic_light_ctrl_2way
// Two-direction (north-south / east-west) intersection controller with
// all-red clearance, latched pedestrian request served in a walk phase, and
// a seconds-remaining countdown for a display.
//
// Optional feature macro: TLC_FLASH_EN adds input flash_mode and the FLASH
// state (both yellows blinking once per tick).
//
// Ports:
//   clk, reset        : clock; asynchronous active-high reset
//   enable            : 1 = run, 0 = freeze prescaler, countdown and state
//   flash_mode        : (TLC_FLASH_EN only) request flashing-yellow mode
//   ped_req           : pedestrian request, any length >= 1 cycle
//   ns_red/yellow/green, ew_red/yellow/green : lamp drives
//   walk              : pedestrian walk lamp
//   ped_pending       : request latched and not yet served
//   tick              : one-cycle prescaler pulse
//   sec_remaining     : ticks left in the current phase minus one
//   phase             : current state encoding (debug)
// ---------------------------------------------------------------------------
module traffic_light_ctrl_2way
  import tlc_pkg::*;
#(
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int GREEN_S    = DEF_GREEN_S,
  parameter int YELLOW_S   = DEF_YELLOW_S,
  parameter int RED_CLR_S  = DEF_RED_CLR_S,
  parameter int PED_WALK_S = DEF_PED_WALK_S,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
`ifdef TLC_FLASH_EN
  input  logic             flash_mode,
`endif
  input  logic             ped_req,
  output logic             ns_red,
  output logic             ns_yellow,
  output logic             ns_green,
  output logic             ew_red,
  output logic             ew_yellow,
  output logic             ew_green,
  output logic             walk,
  output logic             ped_pending,
  output logic             tick,
  output logic [CNT_W-1:0] sec_remaining,
  output logic [2:0]       phase
);

  localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_S - 1);
  localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_S - 1);
  localparam logic [CNT_W-1:0] RED_LD    = CNT_W'(RED_CLR_S - 1);
  localparam logic [CNT_W-1:0] WALK_LD   = CNT_W'(PED_WALK_S - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);

  localparam logic DIR_NS = 1'b0;
  localparam logic DIR_EW = 1'b1;

  localparam lamp_bus_t LAMPS_RESET = {LAMP_RED, LAMP_RED, 1'b0};

  // Countdown value loaded on entry to a state.
  function automatic logic [CNT_W-1:0] load_value(input tlc_state_e st);
    logic [CNT_W-1:0] v;
    case (st)
      ST_NSG, ST_EWG: v = GREEN_LD;
      ST_NSY, ST_EWY: v = YELLOW_LD;
      ST_WALK:        v = WALK_LD;
      ST_FLASH:       v = CNT_ZERO;
      default:        v = RED_LD;
    endcase
    return v;
  endfunction

  tlc_state_e       r_state;
  tlc_state_e       w_state_seq;
  tlc_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_next_dir;
  logic             w_next_dir_nxt;
  logic             r_flash_on;
  logic             w_flash_on_nxt;
  logic             r_ped_pending;
  logic             w_enter_walk;
  lamp_bus_t        r_lamps;
  lamp_bus_t        w_lamps_nxt;
  logic             w_tick;
  logic             w_cnt_zero;
  logic             w_phase_done;

  tlc_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk      (clk),
    .reset    (reset),
    .i_enable (enable),
    .o_tick   (w_tick)
  );

  assign w_cnt_zero   = (r_cnt == CNT_ZERO);
  assign w_phase_done = w_tick & w_cnt_zero;

  // Next-state, countdown, direction memory, flash phase and lamp decode.
  always_comb begin
    w_state_seq    = r_state;
    w_next_dir_nxt = r_next_dir;

    case (r_state)
      ST_ARN: begin
        if (w_phase_done) begin
          if (r_ped_pending) begin
            w_state_seq    = ST_WALK;
            w_next_dir_nxt = DIR_NS;
          end else begin
            w_state_seq = ST_NSG;
          end
        end else begin
          w_state_seq = r_state;
        end
      end
      ST_NSG: w_state_seq = w_phase_done ? ST_NSY : r_state;
      ST_NSY: w_state_seq = w_phase_done ? ST_ARE : r_state;
      ST_ARE: begin
        if (w_phase_done) begin
          if (r_ped_pending) begin
            w_state_seq    = ST_WALK;
            w_next_dir_nxt = DIR_EW;
          end else begin
            w_state_seq = ST_EWG;
          end
        end else begin
          w_state_seq = r_state;
        end
      end
      ST_EWG: w_state_seq = w_phase_done ? ST_EWY : r_state;
      ST_EWY: w_state_seq = w_phase_done ? ST_ARN : r_state;
      ST_WALK: begin
        if (w_phase_done) begin
          w_state_seq = (r_next_dir == DIR_EW) ? ST_EWG : ST_NSG;
        end else begin
          w_state_seq = r_state;
        end
      end
`ifdef TLC_FLASH_EN
      // Leaving FLASH only happens on a tick where flash_mode has dropped;
      // a tick with flash_mode high is overridden below.
      ST_FLASH: w_state_seq = w_tick ? ST_ARN : r_state;
`endif
      // Illegal or unbuilt encodings recover to all-red immediately.
      default: w_state_seq = ST_ARN;
    endcase

`ifdef TLC_FLASH_EN
    w_state_nxt = (w_tick && flash_mode) ? ST_FLASH : w_state_seq;
`else
    w_state_nxt = w_state_seq;
`endif

    // Any state change reloads; self-loops only decrement on a tick.
    if (w_state_nxt != r_state) begin
      w_cnt_nxt = load_value(w_state_nxt);
    end else if (w_tick && !w_cnt_zero) begin
      w_cnt_nxt = r_cnt - CNT_ONE;
    end else begin
      w_cnt_nxt = r_cnt;
    end

    // Yellows start lit on FLASH entry and toggle on every later tick.
    if (w_state_nxt == ST_FLASH) begin
      if (r_state != ST_FLASH) begin
        w_flash_on_nxt = 1'b1;
      end else if (w_tick) begin
        w_flash_on_nxt = ~r_flash_on;
      end else begin
        w_flash_on_nxt = r_flash_on;
      end
    end else begin
      w_flash_on_nxt = 1'b0;
    end

    w_enter_walk = (w_state_nxt == ST_WALK) && (r_state != ST_WALK);
    w_lamps_nxt  = decode_lamps(w_state_nxt, w_flash_on_nxt);
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_ARN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Countdown, direction memory, flash phase, pedestrian latch and lamps.
  // Lamps are decoded from the next state so they register alongside it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt         <= RED_LD;
      r_next_dir    <= DIR_NS;
      r_flash_on    <= 1'b0;
      r_ped_pending <= 1'b0;
      r_lamps       <= LAMPS_RESET;
    end else begin
      r_cnt         <= w_cnt_nxt;
      r_next_dir    <= w_next_dir_nxt;
      r_flash_on    <= w_flash_on_nxt;
      // A request arriving on the walk-entry cycle survives the clear.
      r_ped_pending <= ped_req | (r_ped_pending & ~w_enter_walk);
      r_lamps       <= w_lamps_nxt;
    end
  end

  assign ns_red        = r_lamps.ns.red;
  assign ns_yellow     = r_lamps.ns.yellow;
  assign ns_green      = r_lamps.ns.green;
  assign ew_red        = r_lamps.ew.red;
  assign ew_yellow     = r_lamps.ew.yellow;
  assign ew_green      = r_lamps.ew.green;
  assign walk          = r_lamps.walk;
  assign ped_pending   = r_ped_pending;
  assign tick          = w_tick;
  assign sec_remaining = r_cnt;
  assign phase         = r_state;

endmodule

// File: tb/tb_traffic_light_ctrl_2way.sv
// Scoreboard bench: each scenario queues the expected controller state for
// every tick; a monitor pops one entry per tick and compares.
module tb_traffic_light_ctrl_2way;

  localparam int TICK_DIV = 4, GREEN_S = 3, YELLOW_S = 2, RED_CLR_S = 1, PED_WALK_S = 2, CNT_W = 8;

  localparam logic [2:0] P_ARN = 3'd0, P_NSG = 3'd1, P_NSY = 3'd2, P_ARE = 3'd3,
                         P_EWG = 3'd4, P_EWY = 3'd5, P_WALK = 3'd6, P_FLASH = 3'd7;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic ped_req = 1'b0;
`ifdef TLC_FLASH_EN
  logic flash_mode = 1'b0;
`endif
  logic ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk, ped_pending, tick;
  logic [CNT_W-1:0] sec_remaining;
  logic [2:0] phase;

  traffic_light_ctrl_2way #(
    .TICK_DIV(TICK_DIV), .GREEN_S(GREEN_S), .YELLOW_S(YELLOW_S),
    .RED_CLR_S(RED_CLR_S), .PED_WALK_S(PED_WALK_S), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
`ifdef TLC_FLASH_EN
    .flash_mode(flash_mode),
`endif
    .ped_req(ped_req),
    .ns_red(ns_red), .ns_yellow(ns_yellow), .ns_green(ns_green),
    .ew_red(ew_red), .ew_yellow(ew_yellow), .ew_green(ew_green),
    .walk(walk), .ped_pending(ped_pending), .tick(tick),
    .sec_remaining(sec_remaining), .phase(phase)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release; the first edge after release is 1.
  int cyc;
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  typedef struct {
    int         cyc;
    logic [2:0] phase;
    logic [7:0] sec;
    logic [6:0] lamps;
    logic       ped;
  } exp_t;

  exp_t  exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  bit    mon_en  = 1'b0;
  int    exp_cyc = 0;
  string scen    = "init";

  logic [6:0] act_lamps;
  assign act_lamps = {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk};

  // Expected {ns r,y,g, ew r,y,g, walk} for each state.
  function automatic logic [6:0] lamps_for(input logic [2:0] ph, input logic fl);
    case (ph)
      P_NSG:   return 7'b0011000;
      P_NSY:   return 7'b0101000;
      P_EWG:   return 7'b1000010;
      P_EWY:   return 7'b1000100;
      P_WALK:  return 7'b1001001;
      P_FLASH: return {1'b0, fl, 1'b0, 1'b0, fl, 1'b0, 1'b0};
      default: return 7'b1001000;
    endcase
  endfunction

  // Queue 'count' consecutive ticks of one state, countdown from first_sec.
  task automatic push_ticks(input logic [2:0] ph, input int first_sec, input int count,
                            input logic ped, input logic fl);
    for (int i = 0; i < count; i++) begin
      exp_t e;
      e.cyc   = exp_cyc;
      e.phase = ph;
      e.sec   = 8'(first_sec - i);
      e.lamps = lamps_for(ph, fl);
      e.ped   = ped;
      exp_q.push_back(e);
      exp_cyc += TICK_DIV;
    end
  endtask

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s/%s: got %0d, required %0d", scen, name, act, req);
    end
  endtask

  // Monitor: one scoreboard entry per tick.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && !reset && tick) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL %s/unexpected_tick: cyc=%0d phase=%0d sec=%0d, required no tick",
                 scen, cyc, phase, sec_remaining);
      end else begin
        e = exp_q.pop_front();
        if (cyc !== e.cyc || phase !== e.phase || sec_remaining !== e.sec ||
            act_lamps !== e.lamps || ped_pending !== e.ped) begin
          n_fail++;
          $display("FAIL %s/tick: got cyc=%0d phase=%0d sec=%0d lamps=%b ped=%b, required cyc=%0d phase=%0d sec=%0d lamps=%b ped=%b",
                   scen, cyc, phase, sec_remaining, act_lamps, ped_pending,
                   e.cyc, e.phase, e.sec, e.lamps, e.ped);
        end
      end
    end
  end

  task automatic hold_reset();
    mon_en  = 1'b0;
    reset   = 1'b1;
    enable  = 1'b0;
    ped_req = 1'b0;
`ifdef TLC_FLASH_EN
    flash_mode = 1'b0;
`endif
    exp_q.delete();
    exp_cyc = TICK_DIV - 1;
    repeat (3) @(negedge clk);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset  = 1'b0;
    enable = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic wait_cyc(input int c);
    int k = 0;
    while (cyc < c && k < 1000) begin
      @(negedge clk);
      k++;
    end
  endtask

  // Wait for the monitor to consume every queued entry, bounded.
  task automatic drain(input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("queue_drained", exp_q.size(), 0);
    exp_q.delete();
    mon_en = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_phase"}, 32'(phase), 32'(P_ARN));
    check({tag, "_sec"},   32'(sec_remaining), 0);
    check({tag, "_lamps"}, 32'(act_lamps), 32'(lamps_for(P_ARN, 1'b0)));
    check({tag, "_ped"},   32'(ped_pending), 0);
    check({tag, "_tick"},  32'(tick), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Plain cycle: two full 48-clock periods with no pedestrian.
    scen = "cycle";
    hold_reset();
    #1 check_reset_state("in_reset");
    push_ticks(P_ARN, 0, 1, 1'b0, 1'b0);
    for (int r = 0; r < 2; r++) begin
      push_ticks(P_NSG, 2, 3, 1'b0, 1'b0);
      push_ticks(P_NSY, 1, 2, 1'b0, 1'b0);
      push_ticks(P_ARE, 0, 1, 1'b0, 1'b0);
      push_ticks(P_EWG, 2, 3, 1'b0, 1'b0);
      push_ticks(P_EWY, 1, 2, 1'b0, 1'b0);
      push_ticks(P_ARN, 0, 1, 1'b0, 1'b0);
    end
    release_reset();
    #1 check_reset_state("after_release");
    drain(200);

    // One-cycle request in NSG, served after ARE, then EWG.
    scen = "ped_pulse";
    hold_reset();
    push_ticks(P_ARN,  0, 1, 1'b0, 1'b0);
    push_ticks(P_NSG,  2, 3, 1'b1, 1'b0);
    push_ticks(P_NSY,  1, 2, 1'b1, 1'b0);
    push_ticks(P_ARE,  0, 1, 1'b1, 1'b0);
    push_ticks(P_WALK, 1, 2, 1'b0, 1'b0);
    push_ticks(P_EWG,  2, 3, 1'b0, 1'b0);
    push_ticks(P_EWY,  1, 2, 1'b0, 1'b0);
    push_ticks(P_ARN,  0, 1, 1'b0, 1'b0);
    push_ticks(P_NSG,  2, 1, 1'b0, 1'b0);
    release_reset();
    wait_cyc(4);
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
    #1 check("ped_latched", 32'(ped_pending), 1);
    drain(200);

    // Request held across WALK entry: second WALK after the next ARN.
    scen = "ped_hold";
    hold_reset();
    push_ticks(P_ARN,  0, 1, 1'b0, 1'b0);
    push_ticks(P_NSG,  2, 3, 1'b1, 1'b0);
    push_ticks(P_NSY,  1, 2, 1'b1, 1'b0);
    push_ticks(P_ARE,  0, 1, 1'b1, 1'b0);
    push_ticks(P_WALK, 1, 2, 1'b1, 1'b0);
    push_ticks(P_EWG,  2, 3, 1'b1, 1'b0);
    push_ticks(P_EWY,  1, 2, 1'b1, 1'b0);
    push_ticks(P_ARN,  0, 1, 1'b1, 1'b0);
    push_ticks(P_WALK, 1, 2, 1'b0, 1'b0);
    push_ticks(P_NSG,  2, 1, 1'b0, 1'b0);
    release_reset();
    wait_cyc(4);
    ped_req = 1'b1;
    wait_cyc(28);
    ped_req = 1'b0;
    #1 check("walk_entered", 32'(phase), 32'(P_WALK));
    check("ped_kept", 32'(ped_pending), 1);
    drain(300);

    // Ten-clock freeze in EWG: remaining time preserved, ticks shift by 10.
    scen = "freeze";
    hold_reset();
    push_ticks(P_ARN, 0, 1, 1'b0, 1'b0);
    push_ticks(P_NSG, 2, 3, 1'b0, 1'b0);
    push_ticks(P_NSY, 1, 2, 1'b0, 1'b0);
    push_ticks(P_ARE, 0, 1, 1'b0, 1'b0);
    push_ticks(P_EWG, 2, 1, 1'b0, 1'b0);
    exp_cyc += 10;
    push_ticks(P_EWG, 1, 2, 1'b0, 1'b0);
    push_ticks(P_EWY, 1, 2, 1'b0, 1'b0);
    push_ticks(P_ARN, 0, 1, 1'b0, 1'b0);
    push_ticks(P_NSG, 2, 1, 1'b0, 1'b0);
    release_reset();
    wait_cyc(32);
    enable = 1'b0;
    repeat (5) @(negedge clk);
    #1 check("frozen_tick", 32'(tick), 0);
    check("frozen_sec",   32'(sec_remaining), 1);
    check("frozen_phase", 32'(phase), 32'(P_EWG));
    check("frozen_lamps", 32'(act_lamps), 32'(lamps_for(P_EWG, 1'b0)));
    repeat (5) @(negedge clk);
    enable = 1'b1;
    drain(300);

    // Asynchronous reset mid-NSY with a pending request.
    scen = "reset_mid";
    hold_reset();
    push_ticks(P_ARN, 0, 1, 1'b0, 1'b0);
    push_ticks(P_NSG, 2, 3, 1'b1, 1'b0);
    release_reset();
    wait_cyc(4);
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
    drain(100);
    wait_cyc(18);
    #1 check("pre_phase", 32'(phase), 32'(P_NSY));
    check("pre_ped", 32'(ped_pending), 1);
    #2 reset = 1'b1;
    #1 check_reset_state("async");

`ifdef TLC_FLASH_EN
    // Flashing yellows entered from EWG, exit through ARN to NSG.
    scen = "flash";
    hold_reset();
    push_ticks(P_ARN,   0, 1, 1'b0, 1'b0);
    push_ticks(P_NSG,   2, 3, 1'b0, 1'b0);
    push_ticks(P_NSY,   1, 2, 1'b0, 1'b0);
    push_ticks(P_ARE,   0, 1, 1'b0, 1'b0);
    push_ticks(P_EWG,   2, 1, 1'b0, 1'b0);
    push_ticks(P_FLASH, 0, 1, 1'b0, 1'b1);
    push_ticks(P_FLASH, 0, 1, 1'b0, 1'b0);
    push_ticks(P_FLASH, 0, 1, 1'b0, 1'b1);
    push_ticks(P_ARN,   0, 1, 1'b0, 1'b0);
    push_ticks(P_NSG,   2, 1, 1'b0, 1'b0);
    release_reset();
    wait_cyc(29);
    flash_mode = 1'b1;
    wait_cyc(40);
    flash_mode = 1'b0;
    drain(300);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
